// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC, requests words from imem, loads the IF/ID register.
// Latency: one instruction per cycle with a zero-wait memory; a word lands in IF/ID on the edge of its ack.
// Backpressure: stall freezes PC and IF/ID; a word acked during stall parks in a one-entry skid buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        if_valid
);

  // FETCH: request outstanding. HOLD: word parked in skid, waiting for stall to clear.
  // DROP: the outstanding request belongs to a squashed path and its word must be thrown away.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;

  logic        redirect;
  logic [31:0] redir_tgt;
  logic [31:0] pc_plus4;

  // Branch has priority over jump; targets are forced word aligned.
  always_comb begin
    redirect  = branch_taken | jump;
    redir_tgt = branch_taken ? {branch_target[31:2], 2'b00} : {jump_target[31:2], 2'b00};
    pc_plus4  = pc_q + 32'd4;
  end

  // Request is held at the current PC in FETCH and DROP; it is masked while reset is asserted.
  always_comb begin
    imem_req  = rst_n && (state_q != S_HOLD);
    imem_addr = pc_q;
  end

  // Next-state and IF/ID load logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    skid_d     = skid_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;

    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          // Redirect beats stall; a word returning this cycle is simply not used.
          if_valid_d = 1'b0;
          if (imem_ack) begin
            pc_d = redir_tgt;
          end else begin
            pend_d  = redir_tgt;
            state_d = S_DROP;
          end
        end else if (imem_ack) begin
          if (stall) begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_pc4_d   = pc_plus4;
            if_valid_d = 1'b1;
            pc_d       = pc_plus4;
          end
        end else if (!stall) begin
          // Downstream took the previous word and nothing new arrived: insert a bubble.
          if_valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          skid_d     = 32'd0;
          pc_d       = redir_tgt;
          state_d    = S_FETCH;
        end else if (!stall) begin
          if_instr_d = skid_q;
          if_pc_d    = pc_q;
          if_pc4_d   = pc_plus4;
          if_valid_d = 1'b1;
          pc_d       = pc_plus4;
          state_d    = S_FETCH;
        end
      end

      S_DROP: begin
        // The newest redirect always wins, even if it coincides with the stale ack.
        if_valid_d = 1'b0;
        if (redirect) begin
          pend_d = redir_tgt;
        end
        if (imem_ack) begin
          pc_d    = redirect ? redir_tgt : pend_q;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      pend_q     <= 32'd0;
      skid_q     <= 32'd0;
      if_pc_q    <= 32'd0;
      if_pc4_q   <= 32'd0;
      if_instr_q <= 32'd0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      skid_q     <= skid_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  // IF/ID register outputs.
  always_comb begin
    if_pc       = if_pc_q;
    if_pc_plus4 = if_pc4_q;
    if_instr    = if_instr_q;
    if_valid    = if_valid_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model, a scoreboard of consumed
// instructions, and a second instance with a reset PC near the top of the address space.
module tb_fetch_unit;

  localparam logic [31:0] PAT = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_pc, if_pc_plus4, if_instr;
  logic        if_valid;

  logic        w_req;
  logic [31:0] w_addr, w_rdata;
  logic [31:0] w_if_pc, w_if_pc4, w_if_instr;
  logic        w_if_valid;

  logic [1:0]  lat;
  logic        mem_en;
  logic [1:0]  cnt;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr), .if_valid(if_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(32'd0),
    .jump(1'b0), .jump_target(32'd0),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_req), .imem_rdata(w_rdata),
    .if_pc(w_if_pc), .if_pc_plus4(w_if_pc4), .if_instr(w_if_instr), .if_valid(w_if_valid)
  );

  assign w_rdata    = w_addr ^ PAT;
  assign imem_rdata = imem_addr ^ PAT;
  assign imem_ack   = mem_en && imem_req && (cnt == lat);

  // Memory model: ack after `lat` request cycles, counter restarts on each ack.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt <= 2'd0;
    else if (imem_ack)                cnt <= 2'd0;
    else if (imem_req && (cnt < lat)) cnt <= cnt + 2'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: an instruction is consumed when it is valid and downstream is not stalling.
  always @(negedge clk) begin
    if (rst_n && if_valid && !stall) begin
      logic [31:0] e;
      chk("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", if_pc, e);
        chk("sb_instr", if_instr, e ^ PAT);
        chk("sb_pc4", if_pc_plus4, e + 32'd4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'd0; jump_target = 32'd0; lat = 2'd0; mem_en = 1'b1;
    step(); step();
    chk("rst_req",    {31'd0, imem_req}, 32'd0);
    chk("rst_addr",   imem_addr, 32'd0);
    chk("rst_valid",  {31'd0, if_valid}, 32'd0);
    chk("rst_pc",     if_pc, 32'd0);
    chk("rst_pc4",    if_pc_plus4, 32'd0);
    chk("rst_instr",  if_instr, 32'd0);
    chk("w_rst_addr", w_addr, 32'hFFFF_FFF8);

    // Zero-latency stream followed by the stalled word at 0x10.
    exp_q.push_back(32'h00); exp_q.push_back(32'h04); exp_q.push_back(32'h08);
    exp_q.push_back(32'h0C); exp_q.push_back(32'h10);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rel_req",  {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'd0);

    step();
    chk("s1_pc",    if_pc, 32'h0);
    chk("s1_valid", {31'd0, if_valid}, 32'd1);
    chk("s1_addr",  imem_addr, 32'h4);
    chk("w1_pc",    w_if_pc, 32'hFFFF_FFF8);
    chk("w1_addr",  w_addr, 32'hFFFF_FFFC);
    step();
    chk("s2_pc",    if_pc, 32'h4);
    chk("w2_addr",  w_addr, 32'h0);
    chk("w2_pc4",   w_if_pc4, 32'h0);
    step();
    chk("s3_pc",    if_pc, 32'h8);
    chk("w3_pc",    w_if_pc, 32'h0);
    step();
    chk("s4_pc",    if_pc, 32'hC);
    lat = 2'd2;

    // Two-cycle memory; stall covers the return of the word at 0x10.
    step(); step();
    chk("s6_valid", {31'd0, if_valid}, 32'd0);
    stall = 1'b1;
    step();
    chk("h7_req",   {31'd0, imem_req}, 32'd0);
    chk("h7_pc",    if_pc, 32'hC);
    step();
    chk("h8_req",   {31'd0, imem_req}, 32'd0);
    step();
    chk("h9_req",   {31'd0, imem_req}, 32'd0);
    chk("h9_valid", {31'd0, if_valid}, 32'd0);
    stall = 1'b0;
    step();
    chk("h10_pc",    if_pc, 32'h10);
    chk("h10_instr", if_instr, 32'h10 ^ PAT);
    chk("h10_valid", {31'd0, if_valid}, 32'd1);
    chk("h10_addr",  imem_addr, 32'h14);
    chk("h10_req",   {31'd0, imem_req}, 32'd1);

    // Jump coinciding with an ack.
    step(); step();
    jump = 1'b1; jump_target = 32'h20;
    step();
    chk("j_addr",  imem_addr, 32'h20);
    chk("j_valid", {31'd0, if_valid}, 32'd0);
    jump = 1'b0;

    // Branch while the 0x20 request is still outstanding.
    step();
    branch_taken = 1'b1; branch_target = 32'h103;
    step();
    chk("d_req",   {31'd0, imem_req}, 32'd1);
    chk("d_addr",  imem_addr, 32'h20);
    chk("d_valid", {31'd0, if_valid}, 32'd0);
    branch_taken = 1'b0;
    step();
    chk("d_new_addr",  imem_addr, 32'h100);
    chk("d_new_valid", {31'd0, if_valid}, 32'd0);

    // Two redirects before the stale ack: the latest target is taken.
    jump = 1'b1; jump_target = 32'h180;
    step();
    chk("o1_addr", imem_addr, 32'h100);
    jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h1C0;
    step();
    chk("o2_addr", imem_addr, 32'h100);
    branch_taken = 1'b0;
    step();
    chk("o3_addr", imem_addr, 32'h1C0);
    lat = 2'd0;
    step();
    chk("l_pc",    if_pc, 32'h1C0);
    chk("l_valid", {31'd0, if_valid}, 32'd1);

    // Branch and jump together under stall: branch wins and IF/ID is flushed.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
    jump = 1'b1; jump_target = 32'h300;
    step();
    chk("bj_addr",  imem_addr, 32'h200);
    chk("bj_valid", {31'd0, if_valid}, 32'd0);
    branch_taken = 1'b0; jump = 1'b0;
    step();
    chk("hs_req",   {31'd0, imem_req}, 32'd0);
    chk("hs_valid", {31'd0, if_valid}, 32'd0);

    // Redirect out of HOLD discards the parked word.
    jump = 1'b1; jump_target = 32'h40;
    step();
    chk("hr_addr", imem_addr, 32'h40);
    chk("hr_req",  {31'd0, imem_req}, 32'd1);
    jump = 1'b0; stall = 1'b0;
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    step(); step();
    chk("t_pc",    if_pc, 32'h44);
    chk("t_pc4",   if_pc_plus4, 32'h48);
    chk("t_instr", if_instr, 32'h44 ^ PAT);
    lat = 2'd2;

    // Asynchronous reset in the middle of a wait, between clock edges.
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("ar_req",    {31'd0, imem_req}, 32'd0);
    chk("ar_addr",   imem_addr, 32'd0);
    chk("ar_pc",     if_pc, 32'd0);
    chk("ar_pc4",    if_pc_plus4, 32'd0);
    chk("ar_instr",  if_instr, 32'd0);
    chk("ar_valid",  {31'd0, if_valid}, 32'd0);
    chk("w_ar_addr", w_addr, 32'hFFFF_FFF8);
    chk("w_ar_pc",   w_if_pc, 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port stall, input, 1 bit: downstream cannot accept; freeze IF/ID outputs and PC.
REQ-005 The block SHALL have port branch_taken, input, 1 bit: redirect to branch_target.
REQ-006 The block SHALL have port branch_target, input, 32 bits: branch destination.
REQ-007 The block SHALL have port jump, input, 1 bit: redirect to jump_target.
REQ-008 The block SHALL have port jump_target, input, 32 bits: jump/jr destination.
REQ-009 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-010 The block SHALL have port imem_addr, output, 32 bits: read address, equal to the current PC.
REQ-011 The block SHALL have port imem_ack, input, 1 bit: imem_rdata valid this cycle; any latency >= 0 cycles after imem_req.
REQ-012 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-013 The block SHALL have ports if_pc and if_pc_plus4, outputs, 32 bits each: address of the instruction in IF/ID, and that address + 4.
REQ-014 The block SHALL have ports if_instr, output, 32 bits, and if_valid, output, 1 bit: IF/ID instruction and its valid flag.

Function
REQ-015 The block SHALL implement a three-state FSM: FETCH (request outstanding), HOLD (word captured, waiting for stall to clear), DROP (outstanding request must be discarded).
REQ-016 In FETCH, imem_req SHALL be 1. imem_addr SHALL remain stable from the first request cycle until imem_ack.
REQ-017 In FETCH, on imem_ack with stall=0 and no redirect, the block SHALL load the IF/ID register: if_instr=imem_rdata, if_pc=PC, if_pc_plus4=PC+4, if_valid=1. It SHALL then set PC=PC+4 and stay in FETCH, which allows one instruction per cycle with zero-latency memory.
REQ-018 In FETCH, on imem_ack with stall=1, the block SHALL store imem_rdata in a one-entry skid buffer, deassert imem_req, and go to HOLD; IF/ID SHALL remain unchanged.
REQ-019 In HOLD, when stall=0, the block SHALL load IF/ID from the skid buffer, advance PC by 4, and return to FETCH.
REQ-020 A redirect is branch_taken=1 or jump=1. If both are asserted, branch_taken SHALL win.
REQ-021 A redirect SHALL override stall.
REQ-022 On a redirect, the block SHALL clear if_valid on the next edge and load PC from the target with bits [1:0] forced to 00.
REQ-023 A redirect in FETCH on the same cycle as imem_ack SHALL discard the returned word, update PC to the target, and stay in FETCH.
REQ-024 A redirect in FETCH without imem_ack SHALL latch the target into a pending register and go to DROP.
REQ-025 In DROP, imem_req SHALL stay 1 at the old address. On imem_ack, the word SHALL be discarded, PC SHALL become the pending target, and the FSM SHALL go to FETCH.
REQ-026 A further redirect received in DROP SHALL overwrite the pending target.
REQ-027 A redirect in HOLD SHALL discard the skid entry, set PC to the target, and go to FETCH.
REQ-028 When stall=1 and no ack or redirect occurs, IF/ID SHALL hold its values, including if_valid.
REQ-029 All PC arithmetic SHALL be modulo 2^32: PC 32'hFFFF_FFFC + 4 yields 32'h0000_0000, with no error flag.

Reset
REQ-030 On rst_n=0, asynchronously: PC=RESET_PC, FSM=FETCH, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, pending target=0, skid buffer=0.
REQ-031 imem_req SHALL be 0 while rst_n=0 and SHALL assert in the first cycle after rst_n deasserts, with imem_addr=RESET_PC.
REQ-032 Reset asserted mid-request SHALL abandon the request. An imem_ack arriving after reset release that belongs to the old request is the memory's responsibility to suppress.

Verification
REQ-033 Zero-latency stream: RESET_PC=0, ack tied to req, rdata=addr^32'hA5A5_A5A5 -> if_pc sequence 0, 4, 8, 12 on consecutive cycles, if_valid=1 from cycle 2.
REQ-034 Stall at ack: 2-cycle latency memory, stall=1 for 3 cycles as the word at 0x10 returns -> if_pc stays at the previous value, imem_req=0 during HOLD, then if_pc=0x10 with the correct word, and no duplicate or lost instruction.
REQ-035 Redirect during wait: request to 0x20 outstanding, branch_taken=1 with target 0x103 -> DROP, word from 0x20 discarded, next imem_addr=0x100, if_valid=0 for at least one cycle.
REQ-036 Simultaneous redirect: branch_taken=1 (target 0x200) and jump=1 (target 0x300) together with stall=1 -> PC=0x200, if_valid=0.
REQ-037 Wrap and reset: RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; asserting rst_n=0 mid-wait -> outputs reach their reset values immediately without waiting for clk.
